lmem_hd_unloader: RTL and testbench

// Reader side of the Lmem unload port: after decoding finishes, walks all unload addresses of

---
 rtl/lmem_hd_unloader.sv | 156 +++++++++++++++
 tb/tb_lmem_hd_unloader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lmem_hd_unloader.sv
// rtl/lmem_hd_unloader.sv - Lmem hard-decision unload reader
// Walks every unload address, captures the Kb-circulant vector and streams it out word by word.
module lmem_hd_unloader #(
  parameter int Kb           = 14,
  parameter int HDWIDTH      = 32,
  parameter int Z            = 511,
  parameter int ADDRESSWIDTH = 5,
  parameter int UNLOAD_DEPTH = 16,
  parameter int UNLOAD_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]   unload_HDout_vec_regout,
  output logic [HDWIDTH-1:0]      hd_data,
  output logic                    hd_valid,
  input  logic                    hd_ready,
  output logic                    hd_last
);

  localparam int WORD_W    = (Kb > 1) ? $clog2(Kb) : 1;
  localparam int LAT_W     = (UNLOAD_LAT > 1) ? $clog2(UNLOAD_LAT) : 1;
  localparam int LAST_BITS = Z - (UNLOAD_DEPTH - 1) * HDWIDTH;

  localparam logic [WORD_W-1:0]       LAST_WORD = WORD_W'(Kb - 1);
  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(UNLOAD_DEPTH - 1);
  localparam logic [LAT_W-1:0]        LAT_MAX   = LAT_W'(UNLOAD_LAT - 1);
  localparam logic [HDWIDTH-1:0]      PAD_MASK  = HDWIDTH'((65'd1 << LAST_BITS) - 65'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [ADDRESSWIDTH-1:0]        r_addr;
  logic [WORD_W-1:0]              r_word;
  logic [LAT_W-1:0]               r_lat;
  logic [Kb-1:0][HDWIDTH-1:0]     r_buf;

  logic                           w_accept;
  logic                           w_last_word;
  logic                           w_last_addr;
  logic [HDWIDTH-1:0]             w_mask;

  assign w_accept      = (r_state == S_SEND) && hd_ready;
  assign w_last_word   = (r_word == LAST_WORD);
  assign w_last_addr   = (r_addr == LAST_ADDR);
  // The final address only carries the tail of the circulant; upper bits are padding.
  assign w_mask        = w_last_addr ? PAD_MASK : {HDWIDTH{1'b1}};
  assign unloadAddress = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    unload_en = 1'b0;
    hd_valid  = 1'b0;
    hd_last   = 1'b0;
    hd_data   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        busy      = 1'b1;
        unload_en = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_lat == LAT_MAX) begin
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        busy     = 1'b1;
        hd_valid = 1'b1;
        hd_data  = r_buf[r_word];
        hd_last  = w_last_word && w_last_addr;
        if (w_accept && w_last_word) begin
          w_next = w_last_addr ? S_FIN : S_REQ;
        end
      end
      S_FIN: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_word <= '0;
      r_lat  <= '0;
      r_buf  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= '0;
          end
        end
        S_REQ: begin
          r_lat <= '0;
        end
        S_WAIT: begin
          // Lmem output is valid exactly on the last latency cycle; grab it then.
          if (r_lat == LAT_MAX) begin
            for (int k = 0; k < Kb; k++) begin
              r_buf[k] <= unload_HDout_vec_regout[k*HDWIDTH +: HDWIDTH] & w_mask;
            end
            r_word <= '0;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (!w_last_word) begin
              r_word <= r_word + 1'b1;
            end else if (!w_last_addr) begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmem_hd_unloader.sv
// tb/tb_lmem_hd_unloader.sv - self-checking bench for lmem_hd_unloader
// Lmem is a two-stage pipelined array; expected words come from a flat address-major list.
module tb_lmem_hd_unloader;

  localparam int KB        = 14;
  localparam int HDW       = 32;
  localparam int ZC        = 511;
  localparam int AW        = 5;
  localparam int DEPTH     = 16;
  localparam int LAT       = 2;
  localparam int NWORDS    = KB * DEPTH;
  localparam int LAST_BITS = ZC - (DEPTH - 1) * HDW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              hd_ready;
  logic              busy;
  logic              done;
  logic              unload_en;
  logic [AW-1:0]     unloadAddress;
  logic [KB*HDW-1:0] vec;
  logic [HDW-1:0]    hd_data;
  logic              hd_valid;
  logic              hd_last;

  logic [KB*HDW-1:0] mem [DEPTH];
  logic [KB*HDW-1:0] p1;
  logic [KB*HDW-1:0] p2;

  int total = 0;
  int bad   = 0;

  lmem_hd_unloader #(
    .Kb(KB), .HDWIDTH(HDW), .Z(ZC), .ADDRESSWIDTH(AW), .UNLOAD_DEPTH(DEPTH), .UNLOAD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .unload_en(unload_en), .unloadAddress(unloadAddress),
    .unload_HDout_vec_regout(vec),
    .hd_data(hd_data), .hd_valid(hd_valid), .hd_ready(hd_ready), .hd_last(hd_last)
  );

  always #5 clk = ~clk;

  function automatic logic [KB*HDW-1:0] rand_vec();
    logic [KB*HDW-1:0] v;
    for (int k = 0; k < KB; k++) v[k*HDW +: HDW] = $urandom();
    return v;
  endfunction

  // Garbage outside the valid window so a mistimed capture is visible.
  always @(posedge clk) begin
    p1 <= unload_en ? mem[unloadAddress[3:0]] : rand_vec();
    p2 <= p1;
  end
  assign vec = p2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en"}, unload_en, 0);
    chk({tag, "_valid"}, hd_valid, 0);
    chk({tag, "_last"}, hd_last, 0);
    chk({tag, "_addr"}, unloadAddress, 0);
    chk({tag, "_data"}, hd_data, 0);
  endtask

  task automatic run_stream(input bit rnd, input int restart_word, input int abort_addr);
    logic [HDW-1:0] exp_q [$];
    logic [HDW-1:0] w;
    logic [HDW-1:0] prev_data;
    int n_words, n_en, n_done, last_en, first_valid, done_cyc, last_acc, low_run, t, abort_tick;
    bit prev_en, prev_stall, pulsed, aborted;

    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < KB; k++) begin
        w = mem[a][k*HDW +: HDW];
        if (a == DEPTH - 1) for (int b = LAST_BITS; b < HDW; b++) w[b] = 1'b0;
        exp_q.push_back(w);
      end
    end

    n_words = 0; n_en = 0; n_done = 0; last_en = -1; first_valid = -1; done_cyc = -1;
    last_acc = -1; low_run = 0; abort_tick = -1;
    prev_en = 0; prev_stall = 0; pulsed = 0; aborted = 0; prev_data = '0;

    @(negedge clk);
    start = 1'b1;
    hd_ready = 1'b1;
    t = 0;
    while (!aborted && t < 4000 && !(done_cyc >= 0 && t >= done_cyc + 5)) begin
      @(negedge clk);
      t++;
      if (t == abort_tick) begin
        rst = 1'b1;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
      end else begin
        start = (restart_word >= 0 && !pulsed && n_words == restart_word);
        if (start) pulsed = 1;
        if (done) begin
          n_done++;
          if (done_cyc < 0) done_cyc = t;
        end
        chk("busy", busy, (done_cyc < 0 || t == done_cyc));
        if (unload_en) begin
          chk("en_b2b", prev_en, 0);
          chk("en_addr", unloadAddress, n_en);
          chk("en_noprefetch", hd_valid, 0);
          if (!rnd && n_en > 0) chk("en_spacing", t - last_en, 17);
          if (abort_addr >= 0 && n_en == abort_addr) abort_tick = t + 1;
          n_en++;
          last_en = t;
        end else if (n_en > 0) begin
          chk("addr_hold", unloadAddress, n_en - 1);
        end
        prev_en = unload_en;
        if (prev_stall) begin
          chk("stall_valid", hd_valid, 1);
          chk("stall_data", hd_data, prev_data);
        end
        if (rnd) begin
          if (low_run >= 10) hd_ready = 1'b1;
          else hd_ready = ($urandom_range(0, 99) < 55);
          low_run = hd_ready ? 0 : low_run + 1;
        end
        chk("last", hd_last, hd_valid && (n_words == NWORDS - 1));
        if (hd_valid && first_valid < 0) first_valid = t;
        if (hd_valid && hd_ready) begin
          if (n_words < NWORDS) chk($sformatf("word%0d", n_words), hd_data, exp_q[n_words]);
          else chk("word_overflow", n_words, NWORDS - 1);
          n_words++;
          last_acc = t;
        end
        prev_stall = hd_valid && !hd_ready;
        prev_data = hd_data;
      end
    end

    start = 1'b0;
    hd_ready = 1'b1;
    if (!aborted) begin
      chk("finished", (done_cyc >= 0), 1);
      chk("word_count", n_words, NWORDS);
      chk("en_count", n_en, DEPTH);
      chk("done_count", n_done, 1);
      chk("done_after_last", done_cyc, last_acc + 1);
      if (!rnd) begin
        chk("first_valid_lat", first_valid, 2 + LAT);
        chk("total_cycles", done_cyc, DEPTH * (1 + LAT + KB) + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    hd_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = rand_vec();
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_stream(0, -1, -1);

    for (int a = 0; a < DEPTH; a++) mem[a] = '1;
    run_stream(0, -1, -1);

    for (int a = 0; a < DEPTH; a++) mem[a] = rand_vec();
    run_stream(1, 50, -1);

    run_stream(0, -1, 7);
    for (int a = 0; a < DEPTH; a++) mem[a] = rand_vec();
    run_stream(0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
